mdu_iterative: RTL and testbench
================================

# mdu_iterative

Iterative RV32M multiply/divide unit that consumes the 5-bit `alu_ctrl` codes with bit 4 set (the M-extension half of the ALU control encoding) and produces the 32-bit result over multiple cycles. It sits beside the single-cycle ALU in EX. It accepts operands on a valid/ready handshake, stalls the pipeline while busy, and returns the result on a second valid/ready handshake.

## Interface
- `XLEN`, 32: operand and result width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operands and op are valid.
- `in_ready`  out  1  unit is idle and can accept an op.
- `alu_ctrl`  in  5  op code; only `1xxxx` is acted on.
- `op_a`  in  32  rs1 value (dividend / multiplicand).
- `op_b`  in  32  rs2 value (divisor / multiplier).
- `out_valid`  out  1  `result` is valid.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  32  final value.
- `busy`  out  1  high in CALC or DONE; drives the EX stall.

## Operation
- Op decode from `alu_ctrl[2:0]`:
  - 000 MUL (low 32 bits)
  - 001 MULH (signed × signed, high)
  - 010 MULHSU (signed × unsigned, high)
  - 011 MULHU (high)
  - 100 DIV
  - 101 DIVU
  - 110 REM
  - 111 REMU
- An op is accepted when `in_valid && in_ready && alu_ctrl[4]`. If `alu_ctrl[4]==0`, the request is ignored: no state change, no output.
- FSM states:
  - IDLE → CALC on accept.
  - CALC → DONE when the 6-bit step counter reaches 31.
  - IDLE → DONE directly on a special case.
  - DONE → IDLE when `out_ready`.
- At accept:
  - Latch the op.
  - Take absolute values of signed operands.
  - Record the result sign: a_sign^b_sign for the product and quotient; a_sign for the remainder.
- Multiply: radix-2 shift-add over a 64-bit unsigned product, one bit per cycle for 32 cycles. The sign fixup is a two's complement of the full 64 bits, then the low or high word is selected.
- Divide: restoring division with a 33-bit partial remainder, one quotient bit per cycle for 32 cycles. Quotient and remainder get separate sign fixups.
- Special cases are resolved at accept with no iteration:
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = op_a (for both signed and unsigned ops).
  - Signed overflow (op_a = 0x80000000, op_b = 0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
- Reset values: `in_ready`=0 during reset and 1 after; `out_valid`=0, `result`=0, `busy`=0; FSM=IDLE; counter=0.
- Reset mid-operation aborts the op; no result is produced.

## Timing
- Accept at edge 0:
  - Normal ops: `out_valid` rises after edge 33 (32 CALC cycles plus 1 fixup cycle).
  - Special cases: `out_valid` rises after edge 1.
- `in_ready` = (state==IDLE). It falls the cycle after accept, so back-to-back accepts are impossible.
- `result` is held stable while `out_valid && !out_ready`. Backpressure is unlimited.
- Handshake completes on the edge where `out_valid && out_ready`:
  - `out_valid` drops the next cycle.
  - `in_ready` rises that same next cycle. The earliest next accept is one cycle after result hand-off.
- `busy` is registered and mirrors `!in_ready` outside reset.

## Configuration
- `MDU_FAST_MUL_EN`:
  - Defined: MUL/MULH/MULHSU/MULHU use a single 33×33 signed `*`. The result is registered and `out_valid` rises after edge 1; divides are unchanged.
  - Undefined: all multiplies use the 33-cycle iterative path. No multiplier is inferred.

## Structure
- Shared package `rv32_pkg`:
  - `alu_ctrl` localparams for all 5-bit codes (ALU_MUL … ALU_REMU, plus base ALU codes).
  - `mdu_state_t` enum {IDLE, CALC, DONE}.
  - `XLEN`.
- One sub-module, `mdu_div_step`: combinational restoring step (33-bit remainder, 32-bit divisor → next remainder, quotient bit). It is instantiated once inside the CALC datapath.

## Test plan
- MUL, a=7, b=0xFFFFFFFD → result 0xFFFFFFEB, `out_valid` after 33 cycles (1 cycle with `MDU_FAST_MUL_EN`).
- Multiply high words:
  - MULH, a=b=0x80000000 → 0x40000000.
  - MULHU, a=b=0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU, a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- Signed divide rounding toward zero:
  - DIV, a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD.
  - REM, same operands → 0xFFFFFFFF.
- Divide by zero:
  - DIVU, a=100, b=0 → 0xFFFFFFFF.
  - REMU, a=100, b=0 → 100.
  - Both with `out_valid` after 1 cycle.
- Overflow: DIV, a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM → 0.
- Handshake and reset:
  - Hold `out_ready`=0 for 10 cycles → `result` stable, `in_ready`=0.
  - Assert `rst` at CALC cycle 15 → `out_valid` never rises, FSM=IDLE.
  - `alu_ctrl`=0x00 with `in_valid` → ignored.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: XLEN, 5-bit ALU control codes (base and M-extension),
// the multiply/divide FSM state type and a small conditional-negate helper.
package rv32_pkg;

  localparam int XLEN = 32;

  // Base ALU control codes (bit 4 clear)
  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_SUB    = 5'b00001;
  localparam logic [4:0] ALU_SLL    = 5'b00010;
  localparam logic [4:0] ALU_SLT    = 5'b00011;
  localparam logic [4:0] ALU_SLTU   = 5'b00100;
  localparam logic [4:0] ALU_XOR    = 5'b00101;
  localparam logic [4:0] ALU_SRL    = 5'b00110;
  localparam logic [4:0] ALU_SRA    = 5'b00111;
  localparam logic [4:0] ALU_OR     = 5'b01000;
  localparam logic [4:0] ALU_AND    = 5'b01001;
  localparam logic [4:0] ALU_LUI    = 5'b01010;

  // M-extension codes (bit 4 set); the low three bits select the operation
  localparam logic [4:0] ALU_MUL    = 5'b10000;
  localparam logic [4:0] ALU_MULH   = 5'b10001;
  localparam logic [4:0] ALU_MULHSU = 5'b10010;
  localparam logic [4:0] ALU_MULHU  = 5'b10011;
  localparam logic [4:0] ALU_DIV    = 5'b10100;
  localparam logic [4:0] ALU_DIVU   = 5'b10101;
  localparam logic [4:0] ALU_REM    = 5'b10110;
  localparam logic [4:0] ALU_REMU   = 5'b10111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  // Two's complement of v when neg is set, otherwise v unchanged
  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
    return neg ? ({XLEN{1'b0}} - v) : v;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step. rem_in is the previous partial remainder already
// shifted left with the next dividend bit appended; if the divisor fits, it is
// subtracted and the quotient bit is 1, otherwise the remainder is kept.
module mdu_div_step
  import rv32_pkg::*;
(
  input  logic [XLEN:0]   rem_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_out,
  output logic            q_bit
);

  logic [XLEN+1:0] diff;

  // Trial subtraction; a borrow out of the top bit means the divisor did not fit
  always_comb begin
    diff    = {1'b0, rem_in} - {2'b00, divisor};
    q_bit   = ~diff[XLEN+1];
    rem_out = q_bit ? diff[XLEN:0] : rem_in;
  end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit. Multiplies use a radix-2 shift-add over a
// 64-bit product register; divides use restoring division one bit per cycle.
// Divide-by-zero and signed overflow are resolved at accept without iterating.
// Optional feature macro: MDU_FAST_MUL_EN (single-cycle 33x33 signed multiply
// for MUL/MULH/MULHSU/MULHU; divides stay iterative).
module mdu_iterative
  import rv32_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  mdu_state_t state, state_next;

  logic [2:0]        op_reg;
  logic              neg_reg;      // sign of product / quotient
  logic              rem_neg_reg;  // sign of remainder
  logic              special_reg;  // result already known at accept
  logic [XLEN-1:0]   operand_reg;  // |a| for multiply, |b| for divide
  logic [2*XLEN-1:0] prod_reg;     // product, or special-case value in low word
  logic [XLEN-1:0]   rem_reg;
  logic [XLEN-1:0]   quo_reg;      // dividend shifts out, quotient shifts in
  logic [5:0]        cnt_reg;

  // Request decode
  logic [2:0]      op;
  logic            accept, is_div, a_signed, b_signed, a_neg, b_neg;
  logic            div_zero, div_ovf, special, fast_mul;
  logic [XLEN-1:0] a_abs, b_abs, special_val;

  assign op       = alu_ctrl[2:0];
  assign accept   = in_valid && in_ready && alu_ctrl[4];
  assign is_div   = op[2];
  assign a_signed = (op == ALU_MULH[2:0]) || (op == ALU_MULHSU[2:0]) ||
                    (op == ALU_DIV[2:0])  || (op == ALU_REM[2:0]);
  assign b_signed = (op == ALU_MULH[2:0]) || (op == ALU_DIV[2:0]) || (op == ALU_REM[2:0]);
  assign a_neg    = a_signed && op_a[XLEN-1];
  assign b_neg    = b_signed && op_b[XLEN-1];
  assign a_abs    = neg_if(op_a, a_neg);
  assign b_abs    = neg_if(op_b, b_neg);
  assign div_zero = is_div && (op_b == '0);
  assign div_ovf  = is_div && !op[0] && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
  assign special  = div_zero || div_ovf;

  // Special results: op[1] distinguishes remainder from quotient
  always_comb begin
    if (div_zero) special_val = op[1] ? op_a : 32'hFFFF_FFFF;
    else          special_val = op[1] ? 32'h0000_0000 : 32'h8000_0000;
  end

`ifdef MDU_FAST_MUL_EN
  logic signed [2*XLEN+1:0] fast_prod;
  assign fast_mul  = !is_div;
  assign fast_prod = $signed({a_signed && op_a[XLEN-1], op_a}) *
                     $signed({b_signed && op_b[XLEN-1], op_b});
`else
  assign fast_mul = 1'b0;
`endif

  // Iteration datapath
  logic [XLEN:0] mul_sum;
  logic [XLEN:0] step_rem;
  logic          step_q;

  assign mul_sum = {1'b0, prod_reg[2*XLEN-1:XLEN]} +
                   {1'b0, (prod_reg[0] ? operand_reg : {XLEN{1'b0}})};

  mdu_div_step u_div_step (
    .rem_in  ({rem_reg, quo_reg[XLEN-1]}),
    .divisor (operand_reg),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Sign fixup and word selection
  logic [2*XLEN-1:0] mul_full;
  logic [XLEN-1:0]   mul_res, div_res, fix_result;

  always_comb begin
    mul_full   = neg_reg ? ({(2*XLEN){1'b0}} - prod_reg) : prod_reg;
    mul_res    = (op_reg == ALU_MUL[2:0]) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
    div_res    = op_reg[1] ? neg_if(rem_reg, rem_neg_reg) : neg_if(quo_reg, neg_reg);
    fix_result = special_reg ? prod_reg[XLEN-1:0] : (op_reg[2] ? div_res : mul_res);
  end

  // Bits that are structurally unused (alu_ctrl[3], top of the step remainder)
  logic bits_unused;
`ifdef MDU_FAST_MUL_EN
  assign bits_unused = ^{alu_ctrl[3], step_rem[XLEN], fast_prod[2*XLEN+1:2*XLEN]};
`else
  assign bits_unused = ^{alu_ctrl[3], step_rem[XLEN]};
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (special || fast_mul) ? DONE : CALC;
      CALC: if (cnt_reg == 6'd31) state_next = DONE;
      DONE: if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: ready only while idle and not held in reset
  always_comb begin
    in_ready = (state == IDLE) && !rst;
  end

  // Registered busy flag tracks the upcoming state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= 1'b0;
    else     busy <= (state_next != IDLE);
  end

  // Operand latch, iteration and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg      <= '0;
      neg_reg     <= 1'b0;
      rem_neg_reg <= 1'b0;
      special_reg <= 1'b0;
      operand_reg <= '0;
      prod_reg    <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      cnt_reg     <= '0;
      out_valid   <= 1'b0;
      result      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_reg      <= op;
            cnt_reg     <= '0;
            special_reg <= special;
            neg_reg     <= a_neg ^ b_neg;
            rem_neg_reg <= a_neg;
            rem_reg     <= '0;
            quo_reg     <= a_abs;
            if (is_div) begin
              operand_reg <= b_abs;
              prod_reg    <= {{XLEN{1'b0}}, special_val};
            end else begin
              operand_reg <= a_abs;
              prod_reg    <= {{XLEN{1'b0}}, b_abs};
`ifdef MDU_FAST_MUL_EN
              prod_reg    <= fast_prod[2*XLEN-1:0];
              neg_reg     <= 1'b0;
`endif
            end
          end
        end
        CALC: begin
          cnt_reg <= cnt_reg + 6'd1;
          if (op_reg[2]) begin
            rem_reg <= step_rem[XLEN-1:0];
            quo_reg <= {quo_reg[XLEN-2:0], step_q};
          end else begin
            prod_reg <= {mul_sum, prod_reg[XLEN-1:1]};
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            result    <= fix_result;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed cases, handshake/reset checks and
// randomized ops compared against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_mdu_iterative;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [4:0]  alu_ctrl;
  logic [31:0] op_a, op_b, result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mdu_iterative dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: RV32M semantics computed with 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    p  = '0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int model_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0)) return 1;
    if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MDU_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return 33;
  endfunction

  // One full transaction: accept, wait for result, optional backpressure, hand-off
  task automatic run_op(input string tag, input logic [4:0] ctrl, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    int          g;
    int          n;
    logic [31:0] exp;
    exp = model(ctrl[2:0], a, b);
    @(negedge clk);
    g = 0;
    while (!in_ready && g < 100) begin @(negedge clk); g++; end
    check({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
    alu_ctrl = ctrl; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, ".busy_acc"}, {31'b0, busy}, 32'd1);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    check({tag, ".latency"}, 32'(n), 32'(model_latency(ctrl[2:0], a, b)));
    check({tag, ".result"}, result, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ".hold_res"}, result, exp);
      check({tag, ".hold_rdy"}, {31'b0, in_ready}, 32'd0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check({tag, ".ov_drop"}, {31'b0, out_valid}, 32'd0);
    check({tag, ".rdy_back"}, {31'b0, in_ready}, 32'd1);
    check({tag, ".busy_end"}, {31'b0, busy}, 32'd0);
    $display("op %s ctrl=%h a=%h b=%h result=%h expected=%h latency=%0d", tag, ctrl, a, b, result, exp, n);
  endtask

  initial begin
    logic        rose;
    logic [4:0]  rc;
    logic [31:0] ra, rb;
    int          mode;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; alu_ctrl = '0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready", {31'b0, in_ready}, 32'd0);
    check("rst.out_valid", {31'b0, out_valid}, 32'd0);
    check("rst.result", result, 32'd0);
    check("rst.busy", {31'b0, busy}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst.in_ready", {31'b0, in_ready}, 32'd1);

    // Directed cases
    run_op("mul",     5'b10000, 32'd7,          32'hFFFF_FFFD, 0);
    run_op("mulh",    5'b10001, 32'h8000_0000,  32'h8000_0000, 0);
    run_op("mulhu",   5'b10011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0);
    run_op("mulhsu",  5'b10010, 32'hFFFF_FFFF,  32'd2,         0);
    run_op("div",     5'b10100, 32'hFFFF_FFF9,  32'd2,         0);
    run_op("rem",     5'b10110, 32'hFFFF_FFF9,  32'd2,         0);
    run_op("divu0",   5'b10101, 32'd100,        32'd0,         0);
    run_op("remu0",   5'b10111, 32'd100,        32'd0,         0);
    run_op("div_ovf", 5'b10100, 32'h8000_0000,  32'hFFFF_FFFF, 0);
    run_op("rem_ovf", 5'b10110, 32'h8000_0000,  32'hFFFF_FFFF, 0);
    run_op("backpr",  5'b10101, 32'd12345,      32'd67,        10);

    // Reset in the middle of CALC aborts the op
    @(negedge clk);
    alu_ctrl = 5'b10101; op_a = 32'd1000; op_b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #2; rst = 1'b1; #1;
    check("midrst.in_ready", {31'b0, in_ready}, 32'd0);
    check("midrst.out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst.busy", {31'b0, busy}, 32'd0);
    check("midrst.result", result, 32'd0);
    @(negedge clk); rst = 1'b0;
    rose = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) rose = 1'b1;
    end
    check("midrst.never_valid", {31'b0, rose}, 32'd0);
    check("midrst.idle", {31'b0, in_ready}, 32'd1);
    $display("op midrst aborted out_valid_seen=%0d in_ready=%0d", rose, in_ready);

    // Non-M control code with in_valid is ignored
    @(negedge clk);
    alu_ctrl = 5'b00000; op_a = 32'd5; op_b = 32'd6; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1; in_valid = 1'b0;
    check("ignore.in_ready", {31'b0, in_ready}, 32'd1);
    check("ignore.busy", {31'b0, busy}, 32'd0);
    rose = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy) rose = 1'b1;
    end
    check("ignore.no_activity", {31'b0, rose}, 32'd0);
    check("ignore.result", result, 32'd0);
    $display("op ignore ctrl=00 activity=%0d", rose);

    // Randomized ops, with occasional special-case operands
    for (int t = 0; t < 40; t++) begin
      rc   = {1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7))};
      mode = $urandom_range(0, 9);
      ra   = $urandom;
      rb   = $urandom;
      if (mode == 0)      rb = 32'd0;
      else if (mode == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (mode == 2) begin ra = $urandom_range(0, 300); rb = $urandom_range(1, 20); end
      else if (mode == 3) rb = {{16{rb[15]}}, rb[15:0]};
      run_op("rand", rc, ra, rb, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
